cla_seq_adder: RTL

Multi-cycle WIDTH-bit adder that time-multiplexes one 4-bit carry-lookahead slice across WIDTH/4 digit positions, least-significant digit first. Carry is held in a register between cycles.
Operands enter and results leave through valid/ready handshakes, so the block drops into any streaming arithmetic pipeline in the codebase.
Trades latency for area against a full-width CLA.

---
 rtl/cla_seq_adder_pkg.sv | 13 +
 rtl/cla_seq_adder_cla4.sv | 29 ++
 rtl/cla_seq_adder.sv | 116 +++++++++++
 3 files changed

// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the digit-serial carry-lookahead adder.
package cla_seq_adder_pkg;

    // Width of the lookahead slice reused on every pass.
    localparam int unsigned DIGIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/cla_seq_adder_cla4.sv
// 4-bit carry-lookahead slice: every carry is a flat sum of generate/propagate products.
module cla4_slice
    import cla_seq_adder_pkg::*;
(
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             c3,
    output logic             cout
);

    logic [DIGIT-1:0] g;
    logic [DIGIT-1:0] p;
    logic             c1;
    logic             c2;

    assign g = a & b;
    assign p = a ^ b;

    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one 4-bit lookahead slice walks the operands LSB digit first.
module cla_seq_adder
    import cla_seq_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned IDX_W = $clog2(NDIG);

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t             state;
    state_t             next;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic               cout_q;
    logic               ovf_q;
    logic [DIGIT-1:0]   s_sum;
    logic               s_c3;
    logic               s_cout;
    logic               accept;
    logic               last_dig;

    cla4_slice u_slice (
        .a    (a_sr[DIGIT-1:0]),
        .b    (b_sr[DIGIT-1:0]),
        .cin  (carry),
        .sum  (s_sum),
        .c3   (s_c3),
        .cout (s_cout)
    );

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_dig  = (idx == IDX_W'(NDIG - 1));

    assign sum  = res_sr;
    assign cout = cout_q;
    assign ovf  = ovf_q;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // Next-state: accept -> NDIG slice passes -> hold result until consumed.
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (accept)    next = RUN;
            RUN:     if (last_dig)  next = DONE;
            DONE:    if (out_ready) next = IDLE;
            default:                next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, then shift one digit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= {s_sum, res_sr[WIDTH-1:DIGIT]};
                    carry  <= s_cout;
                    idx    <= idx + 1'b1;
                    if (last_dig) begin
                        cout_q <= s_cout;
                        ovf_q  <= s_c3 ^ s_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
